// File: rtl/muldiv_iter_unit_pkg.sv
// Shared encodings for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_iter_unit_pkg;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_CALC = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_unit_step.sv
// One shift-add multiply or restoring-divide iteration; chained per cycle.
module muldiv_iter_unit_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic                div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN:0]       rem_i,
  input  logic [XLEN-1:0]     opnd_i,
  input  logic                bit_i,
  output logic [2*XLEN-1:0]   acc_o,
  output logic [XLEN:0]       rem_o,
  output logic                qbit_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // Divide leaves the quotient LSB clear; the caller ORs qbit_o into it.
  always_comb begin
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (bit_i ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    shifted = {rem_i[XLEN-1:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    qbit_o  = div_i & ~diff[XLEN+1];
    if (div_i) begin
      acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b0};
      rem_o = qbit_o ? diff[XLEN:0] : shifted;
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
      rem_o = rem_i;
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative M-extension unit: FSM, operand/sign handling, step chain and result register.
module muldiv_iter_unit
  import muldiv_iter_unit_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned ITERS = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  md_state_e          state_q, state_d;
  logic [2:0]         f3_q;
  logic [XLEN-1:0]    a_q, b_q, opnd_q, result_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [XLEN:0]      rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_res_q, neg_rem_q, valid_q, busy_q;

  logic               is_div, a_neg, b_neg, special;
  logic [XLEN-1:0]    mag_a, mag_b, special_res, fix_res, quo, rmd;
  logic [2*XLEN-1:0]  prod, acc_d;
  logic [XLEN:0]      rem_d;

  assign is_div = f3_q[2];

  // Operand magnitudes and the divide corner cases, evaluated while in PREP.
  always_comb begin
    a_neg       = op_a_signed(f3_q) & a_q[XLEN-1];
    b_neg       = op_b_signed(f3_q) & b_q[XLEN-1];
    mag_a       = a_neg ? -a_q : a_q;
    mag_b       = b_neg ? -b_q : b_q;
    special     = 1'b0;
    special_res = '0;
    if (is_div && (b_q == '0)) begin
      special     = 1'b1;
      special_res = f3_q[1] ? a_q : '1;
    end else if (is_div && !f3_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1)) begin
      special     = 1'b1;
      special_res = f3_q[1] ? '0 : a_q;
    end
  end

  // Sign fix-up and half/quotient/remainder selection.
  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rmd  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    case (f3_q)
      F3_MUL:                      fix_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             fix_res = quo;
      default:                     fix_res = rmd;
    endcase
  end

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [2*XLEN-1:0] acc_in, acc_s, acc_nx;
    logic [XLEN:0]     rem_in, rem_nx;
    logic              bit_s, qbit_s;
    if (g == 0) begin : g_first
      assign acc_in = acc_q;
      assign rem_in = rem_q;
    end else begin : g_next
      assign acc_in = g_step[g-1].acc_nx;
      assign rem_in = g_step[g-1].rem_nx;
    end
    assign bit_s = is_div ? acc_in[XLEN-1] : acc_in[0];
    muldiv_iter_unit_step #(.XLEN(XLEN)) u_step (
      .div_i  (is_div),
      .acc_i  (acc_in),
      .rem_i  (rem_in),
      .opnd_i (opnd_q),
      .bit_i  (bit_s),
      .acc_o  (acc_s),
      .rem_o  (rem_nx),
      .qbit_o (qbit_s)
    );
    assign acc_nx = acc_s | {{(2*XLEN-1){1'b0}}, qbit_s};
  end

  assign acc_d = g_step[BITS_PER_CYCLE-1].acc_nx;
  assign rem_d = g_step[BITS_PER_CYCLE-1].rem_nx;

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (valid_i) state_d = MD_PREP;
      MD_PREP: state_d = special ? MD_DONE : MD_CALC;
      MD_CALC: if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      MD_DONE: if (ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (kill_i) state_d = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == MD_DONE);
      busy_q  <= (state_d != MD_IDLE);
      case (state_q)
        MD_IDLE: begin
          if (valid_i && !kill_i) begin
            f3_q <= funct3_i;
            a_q  <= op_a_i;
            b_q  <= op_b_i;
          end
        end
        MD_PREP: begin
          neg_res_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          opnd_q    <= is_div ? mag_b : mag_a;
          acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          rem_q     <= '0;
          cnt_q     <= CNT_W'(ITERS);
          if (special && !kill_i) result_q <= special_res;
        end
        MD_CALC: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        MD_FIX: begin
          if (!kill_i) result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign busy_o   = busy_q;

endmodule
